// File: rtl/mapping_back_buffer.sv
// Output-side buffer of the mapping layer: result beats enter a synchronous FIFO
// and leave as an AXI-Stream master with frame (tuser) and line (tlast) framing.
module mapping_back_buffer #(
    parameter int DATA_W       = 96,
    parameter int DEPTH        = 64,
    parameter int PROG_FULL_TH = 40,
    parameter int LINE_PIX     = 320,
    parameter int FRAME_LINES  = 180
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_prog_full,
    output logic              o_s_ready,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              o_overflow,
    output logic              o_frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int PW = $clog2(LINE_PIX);
    localparam int LW = $clog2(FRAME_LINES);

    localparam logic [OW-1:0] OCC_ONE   = OW'(1);
    localparam logic [OW-1:0] OCC_ZERO  = OW'(0);
    localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH + 1);
    localparam logic [OW-1:0] OCC_DEPTH = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_PF    = OW'(PROG_FULL_TH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_PIX - 1);
    localparam logic [PW-1:0] PIX_ZERO  = PW'(0);
    localparam logic [PW-1:0] PIX_ONE   = PW'(1);
    localparam logic [LW-1:0] LN_LAST   = LW'(FRAME_LINES - 1);
    localparam logic [LW-1:0] LN_ZERO   = LW'(0);
    localparam logic [LW-1:0] LN_ONE    = LW'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]       occ_q, occ_d, fifo_cnt_s;
    logic                tvalid_q, tvalid_d, tlast_q, tuser_q;
    logic [DATA_W-1:0]   tdata_q;
    logic [PW-1:0]       pix_q, pix_d;
    logic [LW-1:0]       ln_q, ln_d;
    logic                prog_full_q, s_ready_q, overflow_q, frame_done_q;
    logic                running_s, full_s, pop_s, push_s, load_s, frame_end_s;

    // Occupancy covers the FIFO plus the output register, so the FIFO alone holds occ - tvalid.
    always_comb begin
        running_s   = (state_q != ST_INIT);
        full_s      = (occ_q == OCC_FULL);
        pop_s       = tvalid_q & m_axis_tready;
        push_s      = i_valid & running_s & ~full_s;
        fifo_cnt_s  = occ_q - {{(OW-1){1'b0}}, tvalid_q};
        load_s      = (fifo_cnt_s != OCC_ZERO) && (!tvalid_q || pop_s);
        frame_end_s = pop_s && (pix_q == PIX_LAST) && (ln_q == LN_LAST);

        if (push_s && !pop_s) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!push_s && pop_s) begin
            occ_d = occ_q - OCC_ONE;
        end else begin
            occ_d = occ_q;
        end

        if (load_s) begin
            tvalid_d = 1'b1;
        end else if (pop_s) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        pix_d = pix_q;
        ln_d  = ln_q;
        if (pop_s) begin
            if (pix_q == PIX_LAST) begin
                pix_d = PIX_ZERO;
                ln_d  = (ln_q == LN_LAST) ? LN_ZERO : ln_q + LN_ONE;
            end else begin
                pix_d = pix_q + PIX_ONE;
            end
        end else begin
            pix_d = pix_q;
        end
    end

    // FIFO storage write port; pointers alone define validity so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Control FSM, pointers, output register, framing counters and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_INIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= OCC_ZERO;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            pix_q        <= PIX_ZERO;
            ln_q         <= LN_ZERO;
            prog_full_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT:  state_q <= ST_RUN;
                ST_RUN:   state_q <= frame_end_s ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state_q <= frame_end_s ? ST_FLUSH : ST_RUN;
                default:  state_q <= ST_INIT;
            endcase
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (load_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                tdata_q  <= mem_q[rd_ptr_q];
            end
            occ_q    <= occ_d;
            tvalid_q <= tvalid_d;
            pix_q    <= pix_d;
            ln_q     <= ln_d;
            // Framing bits follow the counters, which only move on a transfer, so they hold during stalls.
            tlast_q      <= tvalid_d && (pix_d == PIX_LAST);
            tuser_q      <= tvalid_d && (pix_d == PIX_ZERO) && (ln_d == LN_ZERO);
            prog_full_q  <= (occ_d >= OCC_PF);
            s_ready_q    <= running_s && (occ_d < OCC_DEPTH);
            overflow_q   <= overflow_q | (i_valid & running_s & full_s);
            frame_done_q <= frame_end_s;
        end
    end

    assign o_prog_full   = prog_full_q;
    assign o_s_ready     = s_ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign o_overflow    = overflow_q;
    assign o_frame_done  = frame_done_q;
endmodule

// File: doc/mapping_back_buffer.md
Name: mapping_back_buffer

Overview:
- Output-side buffer of the mapping layer, at the opposite end of the AXI-Stream path from the input line-buffer distributor.
- Accepts 96-bit result beats (12 channels x 8 bits, MSB = Ch11) pushed by the mapping-layer pipeline without backpressure.
- Stores them in a synchronous FIFO and emits them as an AXI-Stream master, with frame/line framing (tuser = start of frame, tlast = end of line).
- Exports the prog_full and s_ready flags the upstream distributor uses to throttle its own AXI-Stream slave.

Parameters:
- DATA_W, 96, beat width
- DEPTH, 64, FIFO storage entries (power of two)
- PROG_FULL_TH, 40, occupancy at or above which o_prog_full asserts (must be < DEPTH)
- LINE_PIX, 320, beats per output line
- FRAME_LINES, 180, lines per frame

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  result beat strobe from mapping pipeline
- i_data  in  DATA_W  result beat
- o_prog_full  out  1  occupancy >= PROG_FULL_TH
- o_s_ready  out  1  buffer initialised and not full
- m_axis_tvalid  out  1  AXIS master valid
- m_axis_tready  in  1  AXIS downstream ready
- m_axis_tdata  out  DATA_W  AXIS data
- m_axis_tlast  out  1  last beat of a line
- m_axis_tuser  out  1  first beat of a frame
- o_overflow  out  1  sticky: a beat was dropped
- o_frame_done  out  1  one-cycle pulse after the final beat of a frame is transferred

Behaviour:
- Reset: all outputs 0; FIFO empty; pixel/line counters 0; FSM = ST_INIT.
- FSM states:
  - ST_INIT: o_s_ready = 0. Moves to ST_RUN on the next cycle.
  - ST_RUN: normal operation.
  - ST_FLUSH: entered for one cycle after o_frame_done. Counters are already cleared; returns to ST_RUN. FIFO contents are kept, since the next frame may already be buffered.
- Reset mid-operation: any cycle with i_rst high discards FIFO contents and counters and returns to ST_INIT; a beat in flight is lost and o_overflow is cleared.
- Occupancy counts FIFO entries plus the output register, range 0..DEPTH+1. "Full" means occupancy == DEPTH+1.
- Push (i_valid in ST_RUN or ST_FLUSH):
  - Accepted if not full.
  - If full, the beat is dropped and o_overflow sets, even when a pop happens in the same cycle.
  - i_valid in ST_INIT is dropped and does not set o_overflow.
- Pop: occurs when m_axis_tvalid & m_axis_tready; the output register reloads from the FIFO head in the same edge.
- Latency: a push into a completely empty buffer at edge N gives m_axis_tvalid = 1 after edge N+1. Sustained throughput is 1 beat/cycle in both directions.
- AXIS rules:
  - While m_axis_tvalid = 1 and tready = 0, tdata, tlast and tuser are held stable.
  - tvalid never deasserts without a transfer.
- Framing, driven from pixel counter pix (0..LINE_PIX-1) and line counter ln (0..FRAME_LINES-1), which advance on each pop:
  - tlast = (pix == LINE_PIX-1).
  - tuser = (pix == 0 && ln == 0).
  - pix wraps to 0 and increments ln.
  - The pop with pix == LINE_PIX-1 and ln == FRAME_LINES-1 wraps both counters to 0 and pulses o_frame_done on the next cycle.
- Flags:
  - o_prog_full = registered (occupancy >= PROG_FULL_TH), updated each edge.
  - o_s_ready = registered (state != ST_INIT && occupancy < DEPTH), so one slot of slack exists for a beat already in flight.
- Simultaneous push and pop: occupancy is unchanged, and data order is preserved (FIFO head to output register, new beat to FIFO tail).
- Pointer arithmetic is log2(DEPTH) bits with natural wrap. The occupancy counter is log2(DEPTH)+1 bits, saturating at DEPTH+1, with no wrap.

Test Plan:
- Reset, then 1 push of 0x0123...AB with tready = 1 -> tvalid high exactly 2 cycles later with matching data, tuser = 1; o_s_ready = 1 from cycle 2 after reset release.
- Stream 320 beats, tready = 1 -> 320 transfers in order, tlast only on beat 320, tuser only on beat 1, no o_overflow.
- Hold tready = 0, push 66 beats -> o_prog_full asserts after occupancy 40, o_s_ready drops at occupancy 64; beat 66 is dropped and o_overflow = 1; release tready -> exactly 65 beats out, in order.
- Full frame of 57600 beats with random tready (50%) -> o_frame_done pulses once, one cycle after the 57600th transfer; the next frame's first beat has tuser = 1.
- Stall with tvalid = 1 and tready = 0 for 10 cycles while pushes continue -> tdata, tlast and tuser stable throughout, no lost or duplicated beats.
- Assert i_rst for 1 cycle with 20 beats buffered -> tvalid = 0, o_overflow = 0 next cycle, o_s_ready = 0 for 2 cycles; the next beat pushed emerges with tuser = 1.
